// File: rtl/video_mixer_pkg.sv
// Shared types and helpers for the video layer mixer.
package video_mixer_pkg;

    localparam int PIX_BITS = 4;   // default bits per colour channel
    localparam int MAX_CB   = 16;  // widest channel the blend helper handles

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_OPAQUE = 2'b01,
        MODE_KEY    = 2'b10,
        MODE_BLEND  = 2'b11
    } layer_mode_t;

    typedef struct packed {
        logic [PIX_BITS-1:0] r;
        logic [PIX_BITS-1:0] g;
        logic [PIX_BITS-1:0] b;
    } rgb_t;

    // 50% blend of one channel, rounding down; callers zero-extend into MAX_CB bits.
    function automatic logic [MAX_CB-1:0] blend_ch(input logic [MAX_CB-1:0] a,
                                                   input logic [MAX_CB-1:0] b);
        return MAX_CB'(({1'b0, a} + {1'b0, b}) >> 1);
    endfunction

endpackage

// File: rtl/video_layer_mixer_fifo.sv
// Per-layer pixel FIFO. Flush wins over push and pop; no write-to-read bypass.
module pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset_n_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; full blocks push even when popping.
    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/video_layer_mixer.sv
// N-layer compositor: per-layer FIFOs, shadowed mode/background, 2-stage timing pipe.
// Push handshake: a layer entry is taken on a clock edge where layer_valid_i[k] and
// layer_ready_o[k] are both 1, except in the frame_o cycle when FIFOs flush.
module video_layer_mixer
    import video_mixer_pkg::*;
#(
    parameter int NUM_LAYERS = 2,
    parameter int COLOR_BITS = PIX_BITS,
    parameter int FIFO_DEPTH = 16,
    parameter logic [3*COLOR_BITS-1:0] KEY_COLOR = '0
) (
    input  logic                               clk,
    input  logic                               reset_n_i,
    input  logic                               hsync_i,
    input  logic                               vsync_i,
    input  logic                               de_i,
    input  logic [NUM_LAYERS-1:0]              layer_valid_i,
    output logic [NUM_LAYERS-1:0]              layer_ready_o,
    input  logic [NUM_LAYERS*3*COLOR_BITS-1:0] layer_data_i,
    input  logic [2*NUM_LAYERS-1:0]            mode_i,
    input  logic [3*COLOR_BITS-1:0]            bg_color_i,
    input  logic                               err_clr_i,
    output logic                               frame_o,
    output logic                               hsync_o,
    output logic                               vsync_o,
    output logic                               de_o,
    output logic [COLOR_BITS-1:0]              r_o,
    output logic [COLOR_BITS-1:0]              g_o,
    output logic [COLOR_BITS-1:0]              b_o,
    output logic [NUM_LAYERS-1:0]              underflow_o
);

    localparam int PW = 3 * COLOR_BITS;

    logic                    vs_prev_q, vs_prev_d;
    logic                    frame_q, frame_d;
    logic [2*NUM_LAYERS-1:0] mode_sh_q, mode_sh_d;
    logic [PW-1:0]           bg_sh_q, bg_sh_d;
    logic                    s1_hs_q, s1_vs_q, s1_de_q;
    logic                    out_hs_q, out_vs_q, out_de_q;
    logic [PW-1:0]           out_pix_q, out_pix_d;
    logic [NUM_LAYERS-1:0]   uf_q, uf_d;

    logic [NUM_LAYERS-1:0]    fifo_full, fifo_empty, fifo_pop, uf_set;
    logic [NUM_LAYERS*PW-1:0] fifo_rd;
    logic [PW-1:0]            acc;

    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
        pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PW)) u_fifo (
            .clk       (clk),
            .reset_n_i (reset_n_i),
            .push      (layer_valid_i[k]),
            .push_data (layer_data_i[k*PW +: PW]),
            .pop       (fifo_pop[k]),
            .flush     (frame_q),
            .pop_data  (fifo_rd[k*PW +: PW]),
            .full      (fifo_full[k]),
            .empty     (fifo_empty[k])
        );
    end

    assign layer_ready_o = ~fifo_full;

    // Bottom-to-top composite of the S1 pixel; empty layers fall through as transparent.
    always_comb begin
        acc      = bg_sh_q;
        fifo_pop = '0;
        uf_set   = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (s1_de_q && (layer_mode_t'(mode_sh_q[2*k +: 2]) != MODE_OFF)) begin
                if (fifo_empty[k]) begin
                    uf_set[k] = 1'b1;
                end else begin
                    fifo_pop[k] = 1'b1;
                    case (layer_mode_t'(mode_sh_q[2*k +: 2]))
                        MODE_OPAQUE: acc = fifo_rd[k*PW +: PW];
                        MODE_KEY: begin
                            if (fifo_rd[k*PW +: PW] != KEY_COLOR) acc = fifo_rd[k*PW +: PW];
                        end
                        MODE_BLEND: begin
                            for (int c = 0; c < 3; c++) begin
                                acc[c*COLOR_BITS +: COLOR_BITS] = COLOR_BITS'(blend_ch(
                                    MAX_CB'(acc[c*COLOR_BITS +: COLOR_BITS]),
                                    MAX_CB'(fifo_rd[k*PW + c*COLOR_BITS +: COLOR_BITS])));
                            end
                        end
                        default: acc = acc;
                    endcase
                end
            end
        end
    end

    // Frame edge detect, shadow loads, blanked pixel and sticky underflow next-state.
    always_comb begin
        vs_prev_d = vsync_i;
        frame_d   = vs_prev_q && !vsync_i;
        mode_sh_d = frame_q ? mode_i : mode_sh_q;
        bg_sh_d   = frame_q ? bg_color_i : bg_sh_q;
        out_pix_d = s1_de_q ? acc : '0;
        uf_d      = (uf_q & ~{NUM_LAYERS{err_clr_i}}) | uf_set;
    end

    // Pipeline, shadow and flag registers.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            vs_prev_q <= 1'b0;
            frame_q   <= 1'b0;
            mode_sh_q <= '0;
            bg_sh_q   <= '0;
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            s1_de_q   <= 1'b0;
            out_hs_q  <= 1'b0;
            out_vs_q  <= 1'b0;
            out_de_q  <= 1'b0;
            out_pix_q <= '0;
            uf_q      <= '0;
        end else begin
            vs_prev_q <= vs_prev_d;
            frame_q   <= frame_d;
            mode_sh_q <= mode_sh_d;
            bg_sh_q   <= bg_sh_d;
            s1_hs_q   <= hsync_i;
            s1_vs_q   <= vsync_i;
            s1_de_q   <= de_i;
            out_hs_q  <= s1_hs_q;
            out_vs_q  <= s1_vs_q;
            out_de_q  <= s1_de_q;
            out_pix_q <= out_pix_d;
            uf_q      <= uf_d;
        end
    end

    assign frame_o     = frame_q;
    assign hsync_o     = out_hs_q;
    assign vsync_o     = out_vs_q;
    assign de_o        = out_de_q;
    assign r_o         = out_pix_q[2*COLOR_BITS +: COLOR_BITS];
    assign g_o         = out_pix_q[COLOR_BITS +: COLOR_BITS];
    assign b_o         = out_pix_q[0 +: COLOR_BITS];
    assign underflow_o = uf_q;

endmodule

// File: tb/tb_video_layer_mixer.sv
// Directed bench for video_layer_mixer (2 layers, 4-bit channels, depth 16, key 000).
module tb_video_layer_mixer;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b1;
    logic        hsync_i = 1'b0, vsync_i = 1'b0, de_i = 1'b0;
    logic [1:0]  layer_valid_i = '0;
    logic [1:0]  layer_ready_o;
    logic [23:0] layer_data_i = '0;
    logic [3:0]  mode_i = '0;
    logic [11:0] bg_color_i = '0;
    logic        err_clr_i = 1'b0;
    logic        frame_o, hsync_o, vsync_o, de_o;
    logic [3:0]  r_o, g_o, b_o;
    logic [1:0]  underflow_o;

    int checks = 0;
    int failures = 0;

    video_layer_mixer #(
        .NUM_LAYERS(2), .COLOR_BITS(4), .FIFO_DEPTH(16), .KEY_COLOR(12'h000)
    ) dut (
        .clk(clk), .reset_n_i(reset_n_i), .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i),
        .layer_valid_i(layer_valid_i), .layer_ready_o(layer_ready_o), .layer_data_i(layer_data_i),
        .mode_i(mode_i), .bg_color_i(bg_color_i), .err_clr_i(err_clr_i), .frame_o(frame_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o), .r_o(r_o), .g_o(g_o), .b_o(b_o),
        .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push2(input logic [1:0] v, input logic [11:0] d0, input logic [11:0] d1);
        layer_valid_i = v;
        layer_data_i  = {d1, d0};
        tick();
        layer_valid_i = '0;
    endtask

    task automatic frame_start();
        vsync_i = 1'b1;
        tick();
        vsync_i = 1'b0;
        tick();
        tick();
    endtask

    // One isolated visible pixel; output appears two edges after de_i is sampled.
    task automatic pixel_check(input string tag, input logic [11:0] exp);
        de_i = 1'b1;
        tick();
        check({tag, "_lag"}, {31'd0, de_o}, 32'd0);
        de_i = 1'b0;
        tick();
        check({tag, "_de"}, {31'd0, de_o}, 32'd1);
        check({tag, "_rgb"}, {20'd0, r_o, g_o, b_o}, {20'd0, exp});
        tick();
        check({tag, "_blank"}, {20'd0, r_o, g_o, b_o}, 32'd0);
    endtask

    initial begin
        // 1: reset values, frame pulse, background only
        #2 reset_n_i = 1'b0;
        tick();
        check("rst_ready", {30'd0, layer_ready_o}, 32'h3);
        check("rst_outs", {18'd0, frame_o, hsync_o, vsync_o, de_o, r_o, g_o, b_o, underflow_o}, 32'd0);
        reset_n_i = 1'b1;
        mode_i = 4'b0000;
        bg_color_i = 12'h123;
        vsync_i = 1'b1;
        tick();
        check("vs_lag1", {31'd0, vsync_o}, 32'd0);
        check("frame_idle", {31'd0, frame_o}, 32'd0);
        vsync_i = 1'b0;
        tick();
        check("frame_pulse", {31'd0, frame_o}, 32'd1);
        check("vs_lag2", {31'd0, vsync_o}, 32'd1);
        tick();
        check("frame_end", {31'd0, frame_o}, 32'd0);
        check("vs_lag3", {31'd0, vsync_o}, 32'd0);
        pixel_check("bg", 12'h123);

        // 2: opaque under key layer; hsync lag
        mode_i = 4'b1001;
        frame_start();
        push2(2'b11, 12'hF00, 12'h000);
        pixel_check("key_skip", 12'hF00);
        push2(2'b11, 12'hF00, 12'h0F0);
        pixel_check("key_hit", 12'h0F0);
        hsync_i = 1'b1;
        tick();
        check("hs_lag1", {31'd0, hsync_o}, 32'd0);
        hsync_i = 1'b0;
        tick();
        check("hs_lag2", {31'd0, hsync_o}, 32'd1);
        tick();
        check("hs_lag3", {31'd0, hsync_o}, 32'd0);

        // 3: blend
        mode_i = 4'b1101;
        frame_start();
        push2(2'b11, 12'hE00, 12'h0E0);
        pixel_check("blend_770", 12'h770);
        mode_i = 4'b0011;
        bg_color_i = 12'h888;
        frame_start();
        push2(2'b01, 12'h000, 12'h000);
        pixel_check("blend_444", 12'h444);
        check("no_uf", {30'd0, underflow_o}, 32'd0);

        // 4: fill L0, drop the 17th push, drain, flush
        mode_i = 4'b0001;
        bg_color_i = 12'h555;
        frame_start();
        for (int i = 0; i < 16; i++) push2(2'b01, 12'h100 + 12'(i), 12'h000);
        check("full_ready", {30'd0, layer_ready_o}, 32'h2);
        push2(2'b01, 12'hABC, 12'h000);
        check("full_ready2", {30'd0, layer_ready_o}, 32'h2);
        de_i = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            if (i == 16) de_i = 1'b0;
            tick();
            if (i == 0) check("ready_after_pop", {30'd0, layer_ready_o}, 32'h3);
            if (i < 16) check("drain_px", {20'd0, r_o, g_o, b_o}, 32'h100 + 32'(i));
            else begin
                check("drain_uf_px", {20'd0, r_o, g_o, b_o}, 32'h555);
                check("drain_uf", {30'd0, underflow_o}, 32'h1);
            end
        end
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("uf_clr", {30'd0, underflow_o}, 32'd0);
        for (int i = 0; i < 3; i++) push2(2'b01, 12'hF0F, 12'h000);
        frame_start();
        pixel_check("flushed", 12'h555);
        check("flushed_uf", {30'd0, underflow_o}, 32'h1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;

        // 5: underflow on upper layer only; set beats clear
        mode_i = 4'b0101;
        frame_start();
        push2(2'b01, 12'h00F, 12'h000);
        pixel_check("uf_l1_px", 12'h00F);
        check("uf_l1", {30'd0, underflow_o}, 32'h2);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("uf_l1_clr", {30'd0, underflow_o}, 32'd0);
        push2(2'b01, 12'h00F, 12'h000);
        de_i = 1'b1;
        tick();
        de_i = 1'b0;
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("set_over_clr", {30'd0, underflow_o}, 32'h2);
        check("set_over_clr_px", {20'd0, r_o, g_o, b_o}, 32'h00F);
        tick();
        check("uf_sticky", {30'd0, underflow_o}, 32'h2);

        // 6: mode/bg changes wait for frame; async reset mid-line
        mode_i = 4'b0000;
        bg_color_i = 12'hFFF;
        push2(2'b11, 12'h0A0, 12'h00B);
        pixel_check("shadow_hold", 12'h00B);
        frame_start();
        pixel_check("shadow_load", 12'hFFF);
        de_i = 1'b1;
        tick();
        tick();
        check("pre_rst_de", {31'd0, de_o}, 32'd1);
        reset_n_i = 1'b0;
        #1;
        check("rst_async", {27'd0, de_o, r_o, g_o, b_o}, 32'd0);
        check("rst_async_rdy", {30'd0, layer_ready_o}, 32'h3);
        #3 reset_n_i = 1'b1;
        tick();
        tick();
        check("post_rst_de", {31'd0, de_o}, 32'd1);
        check("post_rst_black", {20'd0, r_o, g_o, b_o}, 32'd0);
        frame_start();
        tick();
        check("post_rst_frame", {20'd0, r_o, g_o, b_o}, 32'hFFF);
        de_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
